// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides and a
// one-word holding register so consecutive words stream without a gap bit.
module piso_stream_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] sh;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_valid;

  logic                  accept, beat, frees;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  bit_out;

  assign dout_valid = (state == SHIFT);
  assign dout_last  = dout_valid & (cnt == LAST_CNT);
  assign din_ready  = ~hold_valid;
  assign busy       = dout_valid | hold_valid;

  assign accept = din_valid & din_ready;
  assign beat   = dout_valid & dout_ready;
  assign frees  = ~dout_valid | (beat & dout_last);

  // Whole-vector shifts stay legal when DATA_WIDTH is 1.
  assign sh_next = MSB_FIRST ? (sh << 1) : (sh >> 1);
  assign bit_out = MSB_FIRST ? sh[DATA_WIDTH-1] : sh[0];
  assign dout    = dout_valid & bit_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      sh         <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (frees) begin
      // din_ready is low whenever hold is occupied, so hold and accept never collide here.
      if (hold_valid) begin
        sh         <= hold;
        cnt        <= '0;
        hold_valid <= 1'b0;
        state      <= SHIFT;
      end else if (accept) begin
        sh    <= din;
        cnt   <= '0;
        state <= SHIFT;
      end else begin
        state <= EMPTY;
      end
    end else begin
      if (beat) begin
        sh  <= sh_next;
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        hold       <= din;
        hold_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_piso_stream_serializer.sv
// Scoreboard bench: two 8-bit serializers (LSB-first and MSB-first) share one
// input stream; a negedge monitor pops expected bits on every output beat.
module tb_piso_stream_serializer;
  localparam int W = 8;

  typedef struct packed {
    logic d;
    logic last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         dout_ready;
  logic [1:0]   din_ready, dout, dout_valid, dout_last, busy;

  int checks = 0;
  int errors = 0;

  beat_t sbq[2][$];

  always #5 clk = ~clk;

  piso_stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready[0]), .dout(dout[0]), .dout_valid(dout_valid[0]),
    .dout_ready(dout_ready), .dout_last(dout_last[0]), .busy(busy[0])
  );

  piso_stream_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready[1]), .dout(dout[1]), .dout_valid(dout_valid[1]),
    .dout_ready(dout_ready), .dout_last(dout_last[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the expected serial bits of the first nbits positions of word w.
  task automatic push_word(input logic [W-1:0] w, input int nbits);
    beat_t b;
    for (int i = 0; i < nbits; i++) begin
      b.d = w[i];
      b.last = (i == W - 1);
      sbq[0].push_back(b);
      b.d = w[W-1-i];
      sbq[1].push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat must match the head of its queue.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (dout_valid[k] && dout_ready) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("unexpected_beat_%0d", k), 32'(dout[k]), 32'hx);
          end else begin
            beat_t e;
            e = sbq[k].pop_front();
            chk($sformatf("dout_%0d", k), 32'(dout[k]), 32'(e.d));
            chk($sformatf("dout_last_%0d", k), 32'(dout_last[k]), 32'(e.last));
          end
        end else if (!dout_valid[k]) begin
          chk($sformatf("idle_zero_%0d", k), {30'd0, dout[k], dout_last[k]}, 32'd0);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    chk({name, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({name, "_din_ready"},  32'(din_ready), 32'h3);
    chk({name, "_busy"},       32'(busy), 32'd0);
    chk({name, "_dout"},       {dout, dout_last}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #1;
    // Reset with random handshake activity
    for (int i = 0; i < 2; i++) begin
      din = W'($urandom); din_valid = 1'($urandom); dout_ready = 1'($urandom);
      tick();
    end
    reset = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    check_idle("reset");

    // Single word 8'hB4: LSB 0,0,1,0,1,1,0,1 / MSB 1,0,1,1,0,1,0,0
    din = 8'hB4; din_valid = 1'b1;
    push_word(8'hB4, 8);
    tick();
    din_valid = 1'b0;
    chk("single_first_valid", 32'(dout_valid), 32'h3);
    repeat (8) tick();
    check_idle("single_done");

    // Back-to-back 8'hA5 then 8'h3C
    din = 8'hA5; din_valid = 1'b1;
    push_word(8'hA5, 8);
    push_word(8'h3C, 8);
    tick();
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_valid_%0d", i), 32'(dout_valid), 32'h3);
      chk($sformatf("b2b_din_ready_%0d", i), 32'(din_ready),
          (i >= 1 && i <= 7) ? 32'h0 : 32'h3);
      if (i == 1) din_valid = 1'b0;
      tick();
    end
    check_idle("b2b_done");

    // Backpressure on bit 3 of 8'hB4
    din = 8'hB4; din_valid = 1'b1;
    push_word(8'hB4, 8);
    tick();
    din_valid = 1'b0;
    repeat (3) tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold_%0d", i), {dout, dout_last, dout_valid}, 32'b10_00_11);
    end
    dout_ready = 1'b1;
    repeat (5) tick();
    check_idle("stall_done");

    // Reset mid-word: A5 shifting at bit 3, 3C held
    din = 8'hA5; din_valid = 1'b1;
    push_word(8'hA5, 3);
    tick();
    din = 8'h3C;
    tick();
    din_valid = 1'b0;
    chk("mid_hold_full", 32'(din_ready), 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = W'($urandom); din_valid = 1'($urandom); dout_ready = 1'($urandom);
      tick();
    end
    reset = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    check_idle("mid_reset");
    repeat (20) tick();
    check_idle("mid_after");

    chk("sb_empty_lsb", 32'(sbq[0].size()), 32'd0);
    chk("sb_empty_msb", 32'(sbq[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_stream_serializer.md
# piso_stream_serializer

Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It accepts words on a parallel input, emits them one bit per accepted output beat in LSB- or MSB-first order, and flags the final bit of each word. A one-word holding register lets the next word be accepted while the current one is shifting, so back-to-back words stream with no idle bit between them. It sits between a word-wide producer and a bit-serial link or encoder that may apply backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits; legal range is 1 and above.
- MSB_FIRST, 0, 0 = bit 0 is sent first, 1 = bit DATA_WIDTH-1 is sent first.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- din  input  DATA_WIDTH  parallel word to serialize.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept a word this cycle; equals ~hold_valid.
- dout  output  1  current serial bit; forced to 0 when dout_valid=0.
- dout_valid  output  1  dout carries a valid bit.
- dout_ready  input  1  consumer takes the bit this cycle.
- dout_last  output  1  dout is the final bit of its word; 0 when dout_valid=0.
- busy  output  1  dout_valid | hold_valid.

## Operation
- State: shift register sh[DATA_WIDTH-1:0], bit counter cnt of width max(1,$clog2(DATA_WIDTH)), shifter-occupied flag (drives dout_valid), holding register hold plus hold_valid.
- Two shifter states: EMPTY (dout_valid=0) and SHIFT (dout_valid=1).
- Input accept: din_valid & din_ready at an edge.
- Output beat: dout_valid & dout_ready at an edge.
- "Shifter frees" at an edge: the shifter is EMPTY, or a beat occurs with dout_last=1.
- On an accepting edge:
  - If the shifter frees and hold is empty, din loads directly into sh, with cnt=0 and state SHIFT.
  - Otherwise din goes into hold and hold_valid=1.
- On a freeing edge with hold_valid=1: hold loads into sh, cnt=0, hold_valid=0 and state stays SHIFT.
  - No accept is possible on that edge, because din_ready=0 while hold_valid=1.
- On a freeing edge with nothing pending or accepted: the shifter goes to EMPTY.
- On a non-last beat:
  - cnt increments.
  - sh shifts right (MSB_FIRST=0) or left (MSB_FIRST=1), zero-filled.
- When no beat occurs (dout_ready=0), sh, cnt, dout and dout_last hold exactly.
- dout output:
  - MSB_FIRST=0: dout = sh[0].
  - MSB_FIRST=1: dout = sh[DATA_WIDTH-1].
- dout_last = dout_valid & (cnt == DATA_WIDTH-1).
  - When DATA_WIDTH=1, every bit is last.
- din_ready is combinational from hold_valid only. It never depends on din_valid or dout_ready.
- Reset: on any edge with reset=1, all state clears, and reset overrides any simultaneous accept or beat.
  - sh=0, cnt=0, shifter EMPTY, hold=0, hold_valid=0.
  - Outputs after reset: dout=0, dout_valid=0, dout_last=0, din_ready=1, busy=0.
  - Reset mid-word discards the shifting word and the held word; no partial bits are emitted afterwards.

## Timing
- Latency: a word accepted at edge N into an EMPTY shifter presents its first bit with dout_valid=1 from edge N through edge N+1.
- Throughput: with dout_ready held at 1, one bit per cycle.
  - A new word's bit 0 follows the previous word's last bit on the next cycle, with no gap.
  - Sustained rate is one word per DATA_WIDTH cycles.
- din_ready timing: it falls the cycle after a word lands in hold, and rises the cycle after hold transfers into sh.
- All outputs are registered-state derived; there is no combinational path from din or din_valid to any output.

## Test plan
- Reset: assert reset 2 cycles during random din_valid and dout_ready -> dout=0, dout_valid=0, dout_last=0, din_ready=1 and busy=0 on the first cycle after reset.
- LSB-first, DATA_WIDTH=8, MSB_FIRST=0, din=8'hB4, dout_ready=1 -> dout sequence 0,0,1,0,1,1,0,1 on cycles 1..8, dout_last only on cycle 8, dout_valid=0 on cycle 9.
- MSB-first, same din with MSB_FIRST=1 -> dout sequence 1,0,1,1,0,1,0,0, dout_last on the 8th bit.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 8'h3C is accepted into hold on the cycle after 8'hA5 and din_ready goes low. The 16 bits are contiguous: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. din_ready returns to 1 on the cycle the first bit of 8'h3C appears.
- Backpressure: dout_ready=0 for 3 cycles while bit 3 of 8'hB4 is on dout -> dout=0 and dout_last=0 held stable for those cycles. The full 8-bit sequence is still emitted unchanged, ending with dout_last once.
- Reset mid-word: reset at bit 3 of 8'hA5 with 8'h3C in hold -> next cycle dout_valid=0, din_ready=1, busy=0, and no bits of either word appear afterwards.
